// File: rtl/rank_stream_ctrl.sv
// Start/done sequencer that streams a block of samples from a synchronous source memory
// through a rank-order filter and captures the filtered results into a result buffer.
module rank_stream_ctrl #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned NUM_SAMPLES  = 255,
  parameter int unsigned FILT_LATENCY = 1,
  parameter int unsigned FRAME_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  abort,
  output logic [ADDR_BITS-1:0]  src_addr,
  input  logic [DATA_BITS-1:0]  src_data,
  output logic                  filt_en,
  output logic [DATA_BITS-1:0]  filt_din,
  input  logic [DATA_BITS-1:0]  filt_dout,
  output logic                  res_we,
  output logic [ADDR_BITS-1:0]  res_waddr,
  output logic [DATA_BITS-1:0]  res_wdata,
  input  logic                  browse_up,
  input  logic                  browse_down,
  output logic [ADDR_BITS-1:0]  rd_addr,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] frame_cnt
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Last index as an ADDR_BITS value, so NUM_SAMPLES = 2^ADDR_BITS never overflows a compare.
  localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(NUM_SAMPLES - 1);
  localparam int unsigned VldW = (FILT_LATENCY == 0) ? 1 : FILT_LATENCY;

  logic [1:0]            state_q, state_d;
  logic [ADDR_BITS-1:0]  src_addr_q, src_addr_d;
  logic                  issue_q, issue_d;
  logic [VldW-1:0]       vld_q, vld_d;
  logic [ADDR_BITS-1:0]  res_waddr_q, res_waddr_d;
  logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
  logic [FRAME_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic                  wr_en;
  logic                  last_wr;

  assign wr_en   = (FILT_LATENCY == 0) ? issue_q : vld_q[VldW-1];
  assign last_wr = wr_en && (res_waddr_q == LastAddr);

  always_comb begin
    state_d     = state_q;
    src_addr_d  = src_addr_q;
    issue_d     = (state_q == StFill);
    frame_cnt_d = frame_cnt_q;
    res_waddr_d = res_waddr_q;
    if (wr_en) begin
      res_waddr_d = (res_waddr_q == LastAddr) ? '0 : res_waddr_q + 1'b1;
    end
    vld_d[0] = issue_q;
    for (int i = 1; i < VldW; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StFill;
          src_addr_d  = '0;
          res_waddr_d = '0;
        end
      end
      StFill: begin
        if (src_addr_q == LastAddr) begin
          state_d = StDrain;
        end else begin
          src_addr_d = src_addr_q + 1'b1;
        end
      end
      StDrain: begin
        if (last_wr) begin
          state_d = StDone;
        end
      end
      default: begin
        frame_cnt_d = frame_cnt_q + 1'b1;
        if (continuous) begin
          state_d     = StFill;
          src_addr_d  = '0;
          res_waddr_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
    endcase

    // Abort flushes the valid pipe so no stale write escapes after the frame is dropped.
    if (abort) begin
      state_d     = StIdle;
      issue_d     = 1'b0;
      vld_d       = '0;
      frame_cnt_d = frame_cnt_q;
    end
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    if (browse_up && !browse_down) begin
      rd_addr_d = (rd_addr_q == LastAddr) ? '0 : rd_addr_q + 1'b1;
    end else if (browse_down && !browse_up) begin
      rd_addr_d = (rd_addr_q == '0) ? LastAddr : rd_addr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      src_addr_q  <= '0;
      issue_q     <= 1'b0;
      vld_q       <= '0;
      res_waddr_q <= '0;
      rd_addr_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      src_addr_q  <= src_addr_d;
      issue_q     <= issue_d;
      vld_q       <= vld_d;
      res_waddr_q <= res_waddr_d;
      rd_addr_q   <= rd_addr_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign src_addr  = src_addr_q;
  assign filt_en   = issue_q;
  assign filt_din  = issue_q ? src_data : '0;
  assign res_we    = wr_en;
  assign res_waddr = res_waddr_q;
  assign res_wdata = wr_en ? filt_dout : '0;
  assign rd_addr   = rd_addr_q;
  assign busy      = (state_q == StFill) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_rank_stream_ctrl.sv
// Directed bench: two controllers (latency 1 with 8-bit addresses, latency 3 with 3-bit
// addresses so NUM_SAMPLES fills the whole address space) driven from shared stimulus.
module tb_rank_stream_ctrl;

  logic clk, rst, start, continuous, abort, bu, bd;

  logic [7:0] a1, sd1, fd1, fo1, wa1, wd1, rd1, fc1;
  logic       fe1, we1, busy1, done1;
  logic [2:0] a3, wa3, rd3;
  logic [7:0] sd3, fd3, fo3, wd3, fc3;
  logic       fe3, we3, busy3, done3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ew1 = 0, ew3 = 0, wc1 = 0, wc3 = 0;

  rank_stream_ctrl #(
    .DATA_BITS(8), .ADDR_BITS(8), .NUM_SAMPLES(8), .FILT_LATENCY(1), .FRAME_BITS(8)
  ) u1 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .src_addr(a1), .src_data(sd1), .filt_en(fe1), .filt_din(fd1), .filt_dout(fo1),
    .res_we(we1), .res_waddr(wa1), .res_wdata(wd1), .browse_up(bu), .browse_down(bd),
    .rd_addr(rd1), .busy(busy1), .done(done1), .frame_cnt(fc1)
  );

  rank_stream_ctrl #(
    .DATA_BITS(8), .ADDR_BITS(3), .NUM_SAMPLES(8), .FILT_LATENCY(3), .FRAME_BITS(8)
  ) u3 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .src_addr(a3), .src_data(sd3), .filt_en(fe3), .filt_din(fd3), .filt_dout(fo3),
    .res_we(we3), .res_waddr(wa3), .res_wdata(wd3), .browse_up(bu), .browse_down(bd),
    .rd_addr(rd3), .busy(busy3), .done(done3), .frame_cnt(fc3)
  );

  function automatic logic [7:0] f(input int a);
    return 8'(a * 3 + 5);
  endfunction

  // Source ROMs (one-cycle read) and pass-through filters of the matching latency.
  logic [7:0] fp1;
  logic [7:0] fp3 [3];
  always @(posedge clk) begin
    sd1 <= f(int'(a1));
    sd3 <= f(int'(a3));
    fp1 <= fd1;
    fp3[0] <= fd3;
    fp3[1] <= fp3[0];
    fp3[2] <= fp3[1];
  end
  assign fo1 = fp1;
  assign fo3 = fp3[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write scoreboard: every result write must land in sequence with the filtered sample.
  always @(negedge clk) begin
    if (!rst) begin
      if (we1) begin
        chk("wr1_addr", int'(wa1), ew1);
        chk("wr1_data", int'(wd1), int'(f(ew1)));
        ew1 = (ew1 + 1) % 8;
        wc1++;
      end
      if (we3) begin
        chk("wr3_addr", int'(wa3), ew3);
        chk("wr3_data", int'(wd3), int'(f(ew3)));
        ew3 = (ew3 + 1) % 8;
        wc3++;
      end
    end
  end

  task automatic pulse_start();
    ew1 = 0;
    ew3 = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while ((busy1 || done1 || busy3 || done3) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", int'(n < maxc), 1);
  endtask

  task automatic wait_a1(input int addr, input int maxc);
    int n;
    n = 0;
    while (int'(a1) != addr && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("addr_wait", int'(n < maxc), 1);
  endtask

  typedef struct {
    logic st, bu, bd;
    int   a, fe, we, wa, busy, dn, fc, rd;
  } vec_t;
  vec_t tbl [13];

  initial begin
    int n, nd, fs1, fs3, ws1, ws3, hits;
    int dt [3];

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1, 0, 0, 7};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1, 1, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 2, 1, 1, 0, 1, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 3, 1, 1, 1, 1, 0, 0, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 4, 1, 1, 2, 1, 0, 0, 1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 5, 1, 1, 3, 1, 0, 0, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 6, 1, 1, 4, 1, 0, 0, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 7, 1, 1, 5, 1, 0, 0, 1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 7, 1, 1, 6, 1, 0, 0, 1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 7, 0, 1, 7, 1, 0, 0, 1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 7, 0, 0, 0, 0, 1, 0, 1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 7, 0, 0, 0, 0, 0, 1, 1};

    rst = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    abort = 1'b0;
    bu = 1'b0;
    bd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_src_addr", int'(a1), 0);
    chk("rst_busy", int'(busy1 | busy3), 0);
    chk("rst_done", int'(done1 | done3), 0);
    chk("rst_we", int'(we1 | we3), 0);
    chk("rst_fe", int'(fe1 | fe3), 0);
    chk("rst_frame_cnt", int'(fc1), 0);
    chk("rst_wdata_din", int'(wd1 | fd1), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame, latency 1, with browse wrap and an ignored start mid-frame.
    ew1 = 0;
    ew3 = 0;
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("t%0d_src_addr", i), int'(a1), tbl[i].a);
      chk($sformatf("t%0d_filt_en", i), int'(fe1), tbl[i].fe);
      chk($sformatf("t%0d_res_we", i), int'(we1), tbl[i].we);
      chk($sformatf("t%0d_res_waddr", i), int'(wa1), tbl[i].wa);
      chk($sformatf("t%0d_busy", i), int'(busy1), tbl[i].busy);
      chk($sformatf("t%0d_done", i), int'(done1), tbl[i].dn);
      chk($sformatf("t%0d_frame_cnt", i), int'(fc1), tbl[i].fc);
      chk($sformatf("t%0d_rd_addr", i), int'(rd1), tbl[i].rd);
      chk($sformatf("t%0d_rd_addr3", i), int'(rd3), tbl[i].rd);
      if (fe1) chk($sformatf("t%0d_filt_din", i), int'(fd1), int'(f(i - 2)));
      start = tbl[i].st;
      bu = tbl[i].bu;
      bd = tbl[i].bd;
      @(negedge clk);
    end
    start = 1'b0;
    bu = 1'b0;
    bd = 1'b0;
    wait_idle(50);
    chk("f1_frame_cnt3", int'(fc3), 1);
    chk("f1_writes1", wc1, 8);
    chk("f1_writes3", wc3, 8);

    // Continuous: three frames back to back, spaced NUM_SAMPLES + FILT_LATENCY + 2 cycles.
    continuous = 1'b1;
    pulse_start();
    n = 0;
    nd = 0;
    while (nd < 3 && n < 200) begin
      if (done1) begin
        dt[nd] = cyc;
        nd++;
        if (nd == 3) continuous = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    chk("cont_done_count", nd, 3);
    if (nd == 3) begin
      chk("cont_gap_a", dt[1] - dt[0], 11);
      chk("cont_gap_b", dt[2] - dt[1], 11);
    end
    continuous = 1'b0;
    wait_idle(100);
    chk("cont_frame_cnt1", int'(fc1), 4);
    chk("cont_frame_cnt3", int'(fc3), 4);
    chk("cont_writes1", wc1, 32);
    chk("cont_writes3", wc3, 32);

    // Abort while src_addr = 4: no further writes or done, frame count held.
    fs1 = int'(fc1);
    fs3 = int'(fc3);
    pulse_start();
    wait_a1(4, 20);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy1", int'(busy1), 0);
    chk("abort_busy3", int'(busy3), 0);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      if (we1 || we3 || done1 || done3 || fe1 || fe3) hits++;
      @(negedge clk);
    end
    chk("abort_quiet", hits, 0);
    chk("abort_frame_cnt1", int'(fc1), fs1);
    chk("abort_frame_cnt3", int'(fc3), fs3);
    ws1 = wc1;
    ws3 = wc3;
    pulse_start();
    wait_idle(50);
    chk("post_abort_frame_cnt1", int'(fc1), fs1 + 1);
    chk("post_abort_frame_cnt3", int'(fc3), fs3 + 1);
    chk("post_abort_writes1", wc1 - ws1, 8);
    chk("post_abort_writes3", wc3 - ws3, 8);

    // Asynchronous reset while draining.
    pulse_start();
    wait_a1(7, 20);
    @(negedge clk);
    chk("drain_busy", int'(busy1 && !fe1 == 1'b0 || busy1), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_src_addr", int'(a1), 0);
    chk("arst_res_waddr", int'(wa1), 0);
    chk("arst_rd_addr", int'(rd1), 0);
    chk("arst_frame_cnt", int'(fc1), 0);
    chk("arst_busy", int'(busy1 | busy3), 0);
    chk("arst_we_fe", int'(we1 | fe1 | we3 | fe3), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    wait_idle(50);
    chk("post_rst_frame_cnt1", int'(fc1), 1);
    chk("post_rst_frame_cnt3", int'(fc3), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rank_stream_ctrl.md
Name: rank_stream_ctrl

Overview:
Parametrised sequencer that streams a block of samples from a synchronous source memory through a rank-order filter and captures the filtered results into a result buffer. It generalises the fixed 255-sample free-running feed into a start/done controlled engine. The engine has configurable sample count, filter latency compensation, single-shot or continuous frame mode, and a wrap-around browse pointer for result read-back. It sits between the sample ROM, the filter core and the result RAM inside the top level.

Parameters:
DATA_BITS, 8, sample width
ADDR_BITS, 8, address width of source and result memories
NUM_SAMPLES, 255, samples per frame (2..2^ADDR_BITS)
FILT_LATENCY, 1, cycles from filt_en sample to valid filt_dout (0..15)
FRAME_BITS, 8, width of frame counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin frame when idle
continuous  in  1  1 = restart automatically after each frame
abort  in  1  one-cycle pulse: stop current frame, return to IDLE
src_addr  out  ADDR_BITS  source memory read address
src_data  in  DATA_BITS  source read data, valid 1 cycle after src_addr
filt_en  out  1  filter shift enable (sample on filt_din is consumed)
filt_din  out  DATA_BITS  sample to filter
filt_dout  in  DATA_BITS  filter output
res_we  out  1  result buffer write enable
res_waddr  out  ADDR_BITS  result write address
res_wdata  out  DATA_BITS  result write data
browse_up  in  1  one-cycle pulse (debounced): rd_addr + 1
browse_down  in  1  one-cycle pulse (debounced): rd_addr - 1
rd_addr  out  ADDR_BITS  result read-back address
busy  out  1  high in FILL/DRAIN
done  out  1  one-cycle pulse when last result written
frame_cnt  out  FRAME_BITS  completed frames, wraps modulo 2^FRAME_BITS

Behaviour:
- Reset (async, rst=1): state IDLE; src_addr, res_waddr, rd_addr, frame_cnt = 0; filt_en, res_we, busy, done = 0; filt_din, res_wdata = 0; valid pipeline cleared.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE -> FILL on start. src_addr = 0 on entry.
- FILL: src_addr increments each cycle from 0 to NUM_SAMPLES-1. After the last address is issued -> DRAIN.
- Read-issue flag delayed 1 cycle drives filt_en. filt_din = src_data registered-through (combinational pass of src_data, aligned with filt_en).
- Valid pipe: filt_en delayed FILT_LATENCY cycles drives res_we. res_wdata = filt_dout. res_waddr starts at 0 and increments after each write.
- Total: first res_we occurs 1+FILT_LATENCY cycles after the first FILL cycle. Exactly NUM_SAMPLES writes per frame.
- DRAIN: filt_en = 0. Wait until the NUM_SAMPLES-th write. In that cycle res_we = 1, then -> DONE.
- DONE (one cycle): done = 1, frame_cnt + 1. Next state is FILL if continuous = 1 (address counters reset to 0), else IDLE.
- busy = 1 in FILL and DRAIN only.
- start while not IDLE: ignored.
- abort in any state: -> IDLE next cycle. The valid pipe is cleared, so no further res_we. done is not pulsed and frame_cnt is unchanged. abort has priority over start in the same cycle.
- Browse runs independently of the FSM, in all states:
  - up only: rd_addr + 1, wraps NUM_SAMPLES-1 -> 0.
  - down only: rd_addr - 1, wraps 0 -> NUM_SAMPLES-1.
  - both in the same cycle: no change.
- Mid-operation reset: immediate return to reset values. Partial results already written to the buffer are not erased.
- All counters are unsigned ADDR_BITS. NUM_SAMPLES = 2^ADDR_BITS is legal, and the comparisons must not overflow.

Test Plan:
- NUM_SAMPLES=8, FILT_LATENCY=1, start pulse -> src_addr 0..7 on consecutive cycles. First res_we 2 cycles after FILL entry. res_waddr 0..7. done pulses once. frame_cnt=1. busy falls with done.
- FILT_LATENCY=3, source returns data = address -> filter model (pass-through delay 3) produces res_wdata 0..7 at res_waddr 0..7, with no duplicate or missing writes.
- continuous=1, 3 frames -> done pulses 3 times spaced NUM_SAMPLES+1+FILT_LATENCY+1 cycles apart. frame_cnt=3.
- abort at src_addr=4 -> IDLE next cycle. No res_we after the pipe flush, no done, frame_cnt unchanged. A new start then runs a full 8-sample frame.
- Browse: rd_addr=0 + browse_down -> 7. browse_up at 7 -> 0. up and down together -> unchanged. Browse during busy is accepted.
- rst asserted in DRAIN -> all outputs at reset values asynchronously. start after deassertion runs normally.
